// File: rtl/ysyx_24110006_uart_tx.sv
// ysyx_24110006_uart_tx: AXI4-Lite transmit-only UART.
// A byte FIFO feeds an 8N1 serializer; STATUS reports FIFO and line state.
module ysyx_24110006_uart_tx #(
   parameter int DEPTH = 16,
   parameter int DIV   = 16
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [31:0] i_axi_awaddr,
   input  logic        i_axi_awvalid,
   output logic        o_axi_awready,
   input  logic [31:0] i_axi_wdata,
   input  logic [3:0]  i_axi_wstrb,
   input  logic        i_axi_wvalid,
   output logic        o_axi_wready,
   output logic [1:0]  o_axi_bresp,
   output logic        o_axi_bvalid,
   input  logic        i_axi_bready,
   input  logic [31:0] i_axi_araddr,
   input  logic        i_axi_arvalid,
   output logic        o_axi_arready,
   output logic [31:0] o_axi_rdata,
   output logic [1:0]  o_axi_rresp,
   output logic        o_axi_rvalid,
   input  logic        i_axi_rready,
   output logic        o_tx
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(DIV);

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   localparam logic [3:0] OFF_TXDATA = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;

   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [DW-1:0] LAST_TICK = DW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

   // AXI response registers
   logic          bvalid;
   logic [1:0]    bresp;
   logic          rvalid;
   logic [1:0]    rresp;
   logic [31:0]   rdata;

   // serializer state
   state_t        state;
   logic [7:0]    shreg;
   logic [DW-1:0] tick;
   logic [2:0]    bit_idx;
   logic          tx;
   logic          busy;
   logic          tick_end;

   // handshakes and decode
   logic          wr_fire;
   logic          rd_fire;
   logic          wr_txdata;
   logic          push;
   logic          pop;
   logic [1:0]    wr_resp;
   logic [1:0]    rd_resp;
   logic [31:0]   rd_data;
   logic [31:0]   status;

   logic          unused_bits;

   assign unused_bits = ^{i_axi_awaddr[31:4], i_axi_araddr[31:4],
                          i_axi_wdata[31:8], i_axi_wstrb[3:1]};

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign busy  = (state != IDLE);

   assign o_axi_awready = !bvalid;
   assign o_axi_wready  = !bvalid;
   assign o_axi_arready = !rvalid;

   assign o_axi_bvalid = bvalid;
   assign o_axi_bresp  = bresp;
   assign o_axi_rvalid = rvalid;
   assign o_axi_rresp  = rresp;
   assign o_axi_rdata  = rdata;
   assign o_tx         = tx;

   assign wr_fire   = i_axi_awvalid && i_axi_wvalid && !bvalid;
   assign rd_fire   = i_axi_arvalid && !rvalid;
   assign wr_txdata = (i_axi_awaddr[3:0] == OFF_TXDATA);

   // fullness is the registered value, so a same-cycle pop never admits a push
   assign push = wr_fire && wr_txdata && i_axi_wstrb[0] && !full;

   // the serializer only looks at the registered count, so a fresh push waits a cycle
   assign pop = (state == IDLE) && !empty;

   assign tick_end = (tick == LAST_TICK);

   assign status = {16'h0, 8'(count), 5'h0, busy, empty, full};

   // write response: a full FIFO with the low byte strobed is the only TXDATA error
   always_comb begin
      wr_resp = SLVERR;
      if (wr_txdata) begin
         wr_resp = (i_axi_wstrb[0] && full) ? SLVERR : OKAY;
      end
   end

   // read decode: only STATUS is readable
   always_comb begin
      rd_data = 32'h0;
      rd_resp = SLVERR;
      if (i_axi_araddr[3:0] == OFF_STATUS) begin
         rd_data = status;
         rd_resp = OKAY;
      end
   end

   // write response channel: raise after accept, hold until bready
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         bvalid <= 1'b0;
         bresp  <= OKAY;
      end else if (wr_fire) begin
         bvalid <= 1'b1;
         bresp  <= wr_resp;
      end else if (bvalid && i_axi_bready) begin
         bvalid <= 1'b0;
      end
   end

   // read data channel: capture at accept, hold until rready
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         rvalid <= 1'b0;
         rresp  <= OKAY;
         rdata  <= 32'h0;
      end else if (rd_fire) begin
         rvalid <= 1'b1;
         rresp  <= rd_resp;
         rdata  <= rd_data;
      end else if (rvalid && i_axi_rready) begin
         rvalid <= 1'b0;
      end
   end

   // FIFO payload; contents are discarded on reset through the pointers
   always_ff @(posedge i_clock) begin
      if (push) begin
         mem[wptr] <= i_axi_wdata[7:0];
      end
   end

   // FIFO pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // 8N1 serializer; tx is set on each transition so it is valid for the whole state
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state   <= IDLE;
         shreg   <= 8'h0;
         tick    <= '0;
         bit_idx <= 3'd0;
         tx      <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               tx      <= 1'b1;
               tick    <= '0;
               bit_idx <= 3'd0;
               if (!empty) begin
                  shreg <= mem[rptr];
                  state <= START;
                  tx    <= 1'b0;
               end
            end
            START: begin
               if (tick_end) begin
                  state   <= DATA;
                  tick    <= '0;
                  bit_idx <= 3'd0;
                  tx      <= shreg[0];
               end else begin
                  tick <= tick + DW'(1);
               end
            end
            DATA: begin
               if (tick_end) begin
                  tick <= '0;
                  if (bit_idx == 3'd7) begin
                     state   <= STOP;
                     bit_idx <= 3'd0;
                     tx      <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  tick <= tick + DW'(1);
               end
            end
            STOP: begin
               if (tick_end) begin
                  state <= IDLE;
                  tick  <= '0;
                  tx    <= 1'b1;
               end else begin
                  tick <= tick + DW'(1);
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24110006_uart_tx.sv
// tb_ysyx_24110006_uart_tx: scoreboard bench for the AXI-Lite UART transmitter.
// A frame-level reference model predicts responses, STATUS words and serial frames.
module tb_ysyx_24110006_uart_tx;

   localparam int DEPTH = 4;
   localparam int DIV   = 16;
   localparam int FRAME = 10 * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;
   logic        tx;

   always #5 clk = ~clk;

   ysyx_24110006_uart_tx #(.DEPTH(DEPTH), .DIV(DIV)) dut (
      .i_clock(clk),
      .i_reset(rst),
      .i_axi_awaddr(awaddr),
      .i_axi_awvalid(awvalid),
      .o_axi_awready(awready),
      .i_axi_wdata(wdata),
      .i_axi_wstrb(wstrb),
      .i_axi_wvalid(wvalid),
      .o_axi_wready(wready),
      .o_axi_bresp(bresp),
      .o_axi_bvalid(bvalid),
      .i_axi_bready(bready),
      .i_axi_araddr(araddr),
      .i_axi_arvalid(arvalid),
      .o_axi_arready(arready),
      .o_axi_rdata(rdata),
      .o_axi_rresp(rresp),
      .o_axi_rvalid(rvalid),
      .i_axi_rready(rready),
      .o_tx(tx)
   );

   typedef struct {
      logic [7:0] data;
      int         start;
   } tx_exp_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [1:0]  exp_b [$];
   logic [33:0] exp_r [$];
   tx_exp_t     exp_tx [$];

   // reference model state: queued bytes, cycles left in the current frame
   logic [7:0] mq [$];
   int         rem = 0;
   bit         mb = 0;
   bit         mr = 0;
   bit         tx_busy = 0;
   bit         rnd_hs = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // reference model, evaluated on pre-edge values at every rising edge
   always @(posedge clk) begin : model
      int n;
      bit busy;
      tx_exp_t e;
      cyc++;
      if (rst) begin
         mq.delete();
         exp_b.delete();
         exp_r.delete();
         exp_tx.delete();
         rem = 0;
         mb = 0;
         mr = 0;
      end else begin
         n = mq.size();
         busy = (rem > 0);
         if (awvalid && wvalid && !mb) begin
            mb = 1;
            if (awaddr[3:0] != 4'h0) exp_b.push_back(2'b10);
            else if (!wstrb[0]) exp_b.push_back(2'b00);
            else if (n >= DEPTH) exp_b.push_back(2'b10);
            else begin
               exp_b.push_back(2'b00);
               mq.push_back(wdata[7:0]);
            end
         end else if (mb && bready) begin
            mb = 0;
         end
         if (arvalid && !mr) begin
            mr = 1;
            if (araddr[3:0] == 4'h4)
               exp_r.push_back({2'b00, 16'h0, 8'(n), 5'h0, busy,
                                n == 0, n == DEPTH});
            else
               exp_r.push_back({2'b10, 32'h0});
         end else if (mr && rready) begin
            mr = 0;
         end
         if (rem > 0) begin
            rem--;
         end else if (n > 0) begin
            e.data = mq.pop_front();
            e.start = cyc;
            exp_tx.push_back(e);
            rem = FRAME;
         end
      end
   end

   // write response monitor
   initial begin : bmon
      forever begin
         @(negedge clk);
         if (!rst && bvalid && bready) begin
            if (exp_b.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_unexpected bresp=%b", bresp);
            end else begin
               chk("bresp", bresp, exp_b.pop_front());
            end
         end
      end
   end

   // read data monitor
   initial begin : rmon
      logic [33:0] e;
      forever begin
         @(negedge clk);
         if (!rst && rvalid && rready) begin
            if (exp_r.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL r_unexpected rdata=%h", rdata);
            end else begin
               e = exp_r.pop_front();
               chk("rdata", rdata, e[31:0]);
               chk("rresp", rresp, e[33:32]);
            end
         end
      end
   end

   // serial line monitor: every cycle of each frame is compared
   initial begin : txmon
      tx_exp_t e;
      logic [9:0] fb;
      int bad;
      bit abort;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            tx_busy = 1;
            if (exp_tx.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_unexpected start cycle=%0d", cyc);
               repeat (FRAME) @(negedge clk);
            end else begin
               e = exp_tx.pop_front();
               fb = {1'b1, e.data, 1'b0};
               chk("tx_start_cycle", cyc, e.start);
               bad = 0;
               abort = 0;
               for (int k = 0; k < FRAME; k++) begin
                  if (k > 0) @(negedge clk);
                  if (rst) begin
                     abort = 1;
                     break;
                  end
                  if (tx !== fb[k / DIV]) bad++;
               end
               if (!abort) begin
                  checks++;
                  if (bad != 0) begin
                     errors++;
                     $display("FAIL tx_frame byte=%h bad_cycles=%0d required=0",
                              e.data, bad);
                  end
               end
            end
            tx_busy = 0;
         end
      end
   end

   // random backpressure on the response channels
   initial begin : hs
      forever begin
         @(posedge clk);
         #1;
         if (rnd_hs) begin
            bready = ($urandom_range(0, 3) != 0);
            rready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   task automatic wait_aw_accept();
      int n;
      n = 0;
      @(negedge clk);
      while (!(awready && wready) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL aw_timeout actual=stalled required=accept");
      end
      @(posedge clk);
      #1;
      awvalid = 0;
      wvalid = 0;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
      @(posedge clk);
      #1;
      awaddr = a;
      wdata = d;
      wstrb = s;
      awvalid = 1;
      wvalid = 1;
      wait_aw_accept();
   endtask

   task automatic axi_read(input logic [31:0] a);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      araddr = a;
      arvalid = 1;
      @(negedge clk);
      while (!arready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL ar_timeout actual=stalled required=accept");
      end
      @(posedge clk);
      #1;
      arvalid = 0;
   endtask

   task automatic read_expect(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] r);
      int n;
      n = 0;
      axi_read(a);
      @(negedge clk);
      while (!rvalid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("read_valid", rvalid, 1);
      chk("read_data", rdata, d);
      chk("read_resp", rresp, r);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (n < 6000 && !(mq.size() == 0 && rem == 0 && exp_tx.size() == 0 &&
                           !tx_busy && exp_b.size() == 0 && exp_r.size() == 0)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 6000) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 7))
         0, 1, 2: a = 32'h0;
         3:       a = 32'h4;
         4:       a = 32'h8;
         5:       a = 32'hC;
         6:       a = $urandom & 32'hFFFF_FFF0;
         default: a = $urandom;
      endcase
      return a;
   endfunction

   function automatic logic [3:0] rand_strb();
      logic [3:0] s;
      s = 4'($urandom);
      if ($urandom_range(0, 3) != 0) s[0] = 1'b1;
      return s;
   endfunction

   // watchdog so the run always ends
   initial begin : watchdog
      #3_000_000;
      errors++;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int hi;
      rst = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_awready", awready, 1);
      chk("rst_wready", wready, 1);
      chk("rst_arready", arready, 1);
      chk("rst_bresp", bresp, 0);
      chk("rst_rdata", rdata, 0);
      @(posedge clk);
      #1;
      rst = 0;

      read_expect(32'h4, 32'h0000_0002, 2'b00);
      read_expect(32'h8, 32'h0, 2'b10);
      wait_idle();

      axi_write(32'h0, 32'h55, 4'h1);
      wait_idle();

      axi_write(32'h0, 32'hA5, 4'h2);
      read_expect(32'h4, 32'h0000_0002, 2'b00);
      hi = 0;
      repeat (3 * DIV) begin
         @(negedge clk);
         if (tx === 1'b1) hi++;
      end
      chk("idle_line_high", hi, 3 * DIV);
      axi_write(32'hC, 32'h77, 4'hF);
      wait_idle();

      bready = 0;
      axi_write(32'h0, 32'h11, 4'h1);
      awaddr = 32'h0;
      wdata = 32'h22;
      wstrb = 4'h1;
      awvalid = 1;
      wvalid = 1;
      repeat (5) begin
         @(negedge clk);
         chk("hold_bvalid", bvalid, 1);
         chk("hold_bresp", bresp, 2'b00);
         chk("hold_awready", awready, 0);
      end
      @(posedge clk);
      #1;
      bready = 1;
      wait_aw_accept();
      wait_idle();

      for (int i = 0; i < 5; i++) axi_write(32'h0, 32'h30 + i, 4'h1);
      axi_write(32'h0, 32'h99, 4'h1);
      read_expect(32'h4, 32'h0000_0405, 2'b00);
      wait_idle();

      rnd_hs = 1;
      fork
         for (int i = 0; i < 30; i++) begin
            axi_write(rand_addr(), $urandom, rand_strb());
            repeat ($urandom_range(0, 4)) @(posedge clk);
         end
         for (int j = 0; j < 15; j++) begin
            axi_read(rand_addr());
            repeat ($urandom_range(0, 30)) @(posedge clk);
         end
      join
      rnd_hs = 0;
      @(posedge clk);
      #2;
      bready = 1;
      rready = 1;
      wait_idle();

      axi_write(32'h0, 32'h00, 4'h1);
      axi_write(32'h0, 32'h81, 4'h1);
      axi_write(32'h0, 32'h42, 4'h1);
      @(posedge clk);
      #1;
      bready = 0;
      axi_write(32'h0, 32'h18, 4'h1);
      repeat (2 * DIV) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_tx", tx, 0);
      chk("pre_rst_bvalid", bvalid, 1);
      #2;
      rst = 1;
      #1;
      chk("arst_tx", tx, 1);
      chk("arst_bvalid", bvalid, 0);
      chk("arst_awready", awready, 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      bready = 1;
      read_expect(32'h4, 32'h0000_0002, 2'b00);
      wait_idle();

      repeat (10) @(posedge clk);
      chk("end_b_queue", exp_b.size(), 0);
      chk("end_r_queue", exp_r.size(), 0);
      chk("end_tx_queue", exp_tx.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
